// File: rtl/domain_sequencer.sv
// Power-domain sequencer: enables domains in ascending order, each gated by its init
// pulse with a timeout, and disables them highest-first with a fixed gap between steps.
module domain_sequencer #(
  parameter int  N_DOMAINS      = 4,
  parameter int  TIMEOUT_CYCLES = 32,
  parameter int  GAP_CYCLES     = 4,
  localparam int IDX_W          = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1
) (
  input  logic                 clk,
  input  logic                 async_rst_n,
  input  logic                 power_req,
  input  logic [N_DOMAINS-1:0] domain_init,
  output logic [N_DOMAINS-1:0] domain_enable,
  output logic                 all_ready,
  output logic                 busy,
  output logic                 fault,
  output logic [IDX_W-1:0]     fault_index
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_UP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_DOWN_LAST = CNT_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(N_DOMAINS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_INIT = 3'd1;
  localparam logic [2:0] S_GAP_UP    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_GAP_DOWN  = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  // NOTE: reset asserts asynchronously through both stages but releases only on a clock
  // edge, so no state flop ever sees a deassertion close to its active edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) rst_sync_q <= 2'b00;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [2:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_DOMAINS-1:0] enable_q, enable_d;
  logic [IDX_W-1:0]     fault_index_q, fault_index_d;
  logic                 all_ready_q, busy_q, fault_q;
  logic                 abort;

  always_comb begin
    // NOTE: every variable gets a default first, so no branch can leave one unassigned
    // and infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    enable_d      = enable_q;
    fault_index_d = fault_index_q;
    abort         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (power_req) begin
          enable_d    = '0;
          enable_d[0] = 1'b1;
          idx_d       = '0;
          cnt_d       = '0;
          state_d     = S_WAIT_INIT;
        end
      end

      S_WAIT_INIT: begin
        if (!power_req) begin
          abort = 1'b1;
        end else if (domain_init[idx_q]) begin
          // An init landing on the timeout cycle still counts.
          cnt_d   = '0;
          state_d = (idx_q == LAST_IDX) ? S_RUN : S_GAP_UP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          enable_d      = '0;
          fault_index_d = idx_q;
          idx_d         = '0;
          cnt_d         = '0;
          state_d       = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP_UP: begin
        if (!power_req) begin
          abort = 1'b1;
        end else if (cnt_q == GAP_UP_LAST) begin
          idx_d           = idx_q + 1'b1;
          enable_d[idx_d] = 1'b1;
          cnt_d           = '0;
          state_d         = S_WAIT_INIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        if (!power_req) begin
          enable_d[LAST_IDX] = 1'b0;
          cnt_d              = '0;
          if (N_DOMAINS == 1) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = LAST_IDX - 1'b1;
            state_d = S_GAP_DOWN;
          end
        end
      end

      // idx tracks the highest enable bit still set; a late power_req is ignored here.
      S_GAP_DOWN: begin
        if (cnt_q == GAP_DOWN_LAST) begin
          enable_d[idx_q] = 1'b0;
          cnt_d           = '0;
          if (idx_q == '0) state_d = S_IDLE;
          else             idx_d   = idx_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FAULT: begin
        enable_d = '0;
        if (!power_req) begin
          fault_index_d = '0;
          state_d       = S_IDLE;
        end
      end

      default: begin
        enable_d      = '0;
        idx_d         = '0;
        cnt_d         = '0;
        fault_index_d = '0;
        state_d       = S_IDLE;
      end
    endcase

    // Abandoning a power-up drops the domain being brought up, then unwinds the rest.
    if (abort) begin
      enable_d[idx_q] = 1'b0;
      cnt_d           = '0;
      if (idx_q == '0) begin
        state_d = S_IDLE;
      end else begin
        idx_d   = idx_q - 1'b1;
        state_d = S_GAP_DOWN;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // values from before the edge regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      enable_q      <= '0;
      fault_index_q <= '0;
      all_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      enable_q      <= enable_d;
      fault_index_q <= fault_index_d;
      all_ready_q   <= (state_d == S_RUN);
      busy_q        <= (state_d == S_WAIT_INIT) || (state_d == S_GAP_UP) ||
                       (state_d == S_GAP_DOWN);
      fault_q       <= (state_d == S_FAULT);
    end
  end

  assign domain_enable = enable_q;
  assign all_ready     = all_ready_q;
  assign busy          = busy_q;
  assign fault         = fault_q;
  assign fault_index   = fault_index_q;

endmodule
